// File: rtl/wb_gpio_pkg.sv
// rtl/wb_gpio_pkg.sv - register map, bus widths and helpers for the Wishbone GPIO block
package wb_gpio_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [7:0] OFF_LED_OUT    = 8'h00;
  localparam logic [7:0] OFF_LED_OEB    = 8'h04;
  localparam logic [7:0] OFF_BTN_STATE  = 8'h08;
  localparam logic [7:0] OFF_IRQ_STATUS = 8'h0C;
  localparam logic [7:0] OFF_IRQ_EN     = 8'h10;

  typedef enum logic [2:0] {
    REG_LED_OUT,
    REG_LED_OEB,
    REG_BTN_STATE,
    REG_IRQ_STATUS,
    REG_IRQ_EN,
    REG_NONE
  } reg_idx_e;

  function automatic reg_idx_e decode_reg(input logic [5:0] word);
    case ({word, 2'b00})
      OFF_LED_OUT:    return REG_LED_OUT;
      OFF_LED_OEB:    return REG_LED_OEB;
      OFF_BTN_STATE:  return REG_BTN_STATE;
      OFF_IRQ_STATUS: return REG_IRQ_STATUS;
      OFF_IRQ_EN:     return REG_IRQ_EN;
      default:        return REG_NONE;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] byte_mask(input logic [SEL_W-1:0] sel);
    logic [DATA_W-1:0] m;
    for (int b = 0; b < SEL_W; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus stability counter for one button
// The debounced state flips after DEBOUNCE_CYC consecutive cycles of disagreement.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_state,
  output logic o_rise
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_done;

  assign w_diff = r_sync2 ^ r_state;
  assign w_done = w_diff && (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_state <= ~r_state;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Rise is flagged on the same edge the state flips so status and state move together.
  assign o_state = r_state;
  assign o_rise  = w_done & ~r_state;

endmodule

// File: rtl/wb_gpio_ctrl.sv
// rtl/wb_gpio_ctrl.sv - Wishbone GPIO peripheral: debounced buttons, LEDs with enables, button IRQs
module wb_gpio_ctrl
  import wb_gpio_pkg::*;
#(
  parameter int          NUM_BTN      = 4,
  parameter int          NUM_LED      = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          DEBOUNCE_CYC = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [SEL_W-1:0]   wbs_sel_i,
  input  logic [ADDR_W-1:0]  wbs_adr_i,
  input  logic [DATA_W-1:0]  wbs_dat_i,
  output logic [DATA_W-1:0]  wbs_dat_o,
  output logic               wbs_ack_o,
  output logic               wbs_stall_o,
  input  logic [NUM_BTN-1:0] buttons_i,
  output logic [NUM_LED-1:0] leds_o,
  output logic [NUM_LED-1:0] led_oeb_o,
  output logic               irq_o
);

  logic [NUM_BTN-1:0] w_btn_state;
  logic [NUM_BTN-1:0] w_btn_rise;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
      .i_clk   (wb_clk_i),
      .i_rst   (wb_rst_i),
      .i_pin   (buttons_i[gi]),
      .o_state (w_btn_state[gi]),
      .o_rise  (w_btn_rise[gi])
    );
  end

  logic               r_ack;
  logic [DATA_W-1:0]  r_dat;
  logic [NUM_LED-1:0] r_led;
  logic [NUM_LED-1:0] r_oeb;
  logic [NUM_BTN-1:0] r_stat;
  logic [NUM_BTN-1:0] r_en;
  logic               r_irq;

  logic               w_in_range;
  logic               w_req;
  logic               w_wr;
  reg_idx_e           w_idx;
  logic [DATA_W-1:0]  w_mask;
  logic [DATA_W-1:0]  w_wr_val;
  logic [DATA_W-1:0]  w_led_ext, w_oeb_ext, w_btn_ext, w_stat_ext, w_en_ext;
  logic [DATA_W-1:0]  w_led_new, w_oeb_new, w_en_new;
  logic [DATA_W-1:0]  w_rdata;
  logic [NUM_BTN-1:0] w_clr;
  logic               w_unused;

  // A request is accepted only while no ack is outstanding, giving one ack per two cycles.
  assign w_in_range = (wbs_adr_i[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
  assign w_req      = wbs_cyc_i & wbs_stb_i & w_in_range & ~r_ack & ~wb_rst_i;
  assign w_wr       = w_req & wbs_we_i;
  assign w_idx      = decode_reg(wbs_adr_i[7:2]);
  assign w_mask     = byte_mask(wbs_sel_i);
  assign w_wr_val   = wbs_dat_i & w_mask;

  always_comb begin
    w_led_ext  = '0;
    w_oeb_ext  = '0;
    w_btn_ext  = '0;
    w_stat_ext = '0;
    w_en_ext   = '0;
    w_led_ext[NUM_LED-1:0]  = r_led;
    w_oeb_ext[NUM_LED-1:0]  = r_oeb;
    w_btn_ext[NUM_BTN-1:0]  = w_btn_state;
    w_stat_ext[NUM_BTN-1:0] = r_stat;
    w_en_ext[NUM_BTN-1:0]   = r_en;
  end

  assign w_led_new = (w_led_ext & ~w_mask) | w_wr_val;
  assign w_oeb_new = (w_oeb_ext & ~w_mask) | w_wr_val;
  assign w_en_new  = (w_en_ext  & ~w_mask) | w_wr_val;
  assign w_clr     = (w_wr && w_idx == REG_IRQ_STATUS) ? w_wr_val[NUM_BTN-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_LED_OUT:    w_rdata = w_led_ext;
      REG_LED_OEB:    w_rdata = w_oeb_ext;
      REG_BTN_STATE:  w_rdata = w_btn_ext;
      REG_IRQ_STATUS: w_rdata = w_stat_ext;
      REG_IRQ_EN:     w_rdata = w_en_ext;
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_led  <= '0;
      r_oeb  <= '1;
      r_stat <= '0;
      r_en   <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_ack <= w_req;
      if (w_req) r_dat <= w_rdata;
      if (w_wr && w_idx == REG_LED_OUT) r_led <= w_led_new[NUM_LED-1:0];
      if (w_wr && w_idx == REG_LED_OEB) r_oeb <= w_oeb_new[NUM_LED-1:0];
      if (w_wr && w_idx == REG_IRQ_EN)  r_en  <= w_en_new[NUM_BTN-1:0];
      r_stat <= (r_stat & ~w_clr) | w_btn_rise;
      r_irq  <= |(r_stat & r_en);
    end
  end

  assign w_unused = ^{wbs_adr_i[1:0], w_led_new, w_oeb_new, w_en_new, w_wr_val};

  assign wbs_dat_o   = r_dat;
  assign wbs_ack_o   = r_ack;
  assign wbs_stall_o = w_req;
  assign leds_o      = r_led;
  assign led_oeb_o   = r_oeb;
  assign irq_o       = r_irq;

endmodule
